// File: rtl/signed_mult_bcd_pkg.sv
// Shared types and constants for the signed 8x8 multiply-and-display block.
package signed_mult_bcd_pkg;

  localparam int W_DEF      = 8;
  localparam int PROD_W     = 16;
  localparam int BCD_W      = 20;
  localparam int BCD_DIGITS = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/signed_mult_bcd_bin2bcd_dd.sv
// Combinational double-dabble: 16-bit binary in, 5-digit packed BCD out.
module bin2bcd_dd
  import signed_mult_bcd_pkg::*;
(
  input  logic [PROD_W-1:0] bin,
  output logic [BCD_W-1:0]  bcd
);

  // Digits occupy the upper BCD_W bits of the scratch register, binary the lower.
  logic [BCD_W+PROD_W-1:0] sr;

  // Unrolled shift-add-3: correct every digit >= 5, then shift in the next binary MSB.
  always_comb begin
    sr = {{BCD_W{1'b0}}, bin};
    for (int i = 0; i < PROD_W; i++) begin
      for (int d = 0; d < BCD_DIGITS; d++) begin
        if (sr[PROD_W+4*d +: 4] >= 4'd5)
          sr[PROD_W+4*d +: 4] = sr[PROD_W+4*d +: 4] + 4'd3;
      end
      sr = sr << 1;
    end
  end

  assign bcd = sr[BCD_W+PROD_W-1 -: BCD_W];

endmodule

// File: rtl/signed_mult_bcd.sv
// Signed multiply-and-display: magnitude/sign split, sequential shift-add
// multiply of magnitudes, packed BCD of the product for the display shifter.
// Build option SIGNED_OPS_EN: when defined, operands are two's complement and
// `negative` reports the result sign; otherwise operands are unsigned and
// `negative` is tied low.
//
// state | meaning
// IDLE  | waiting for start; operands sampled on leaving
// BUSY  | W shift-add steps, then one closing step into DONE
// DONE  | result held while start stays high
module signed_mult_bcd
  import signed_mult_bcd_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   multiplier,
  input  logic [W-1:0]   multiplicand,
  output logic [2*W-1:0] product,
  output logic [BCD_W-1:0] bcd,
  output logic           negative,
  output logic           done,
  output logic           busy
);

  localparam int CNT_W = $clog2(W + 1);

  state_t           state;
  logic [W-1:0]     mag_a;
  logic [W-1:0]     mag_b;
  logic [W-1:0]     mplier_q;
  logic [2*W-1:0]   mcand_q;
  logic [2*W-1:0]   acc;
  logic [CNT_W-1:0] cnt;

`ifdef SIGNED_OPS_EN
  logic neg_a;
  logic neg_b;
  logic sign_q;

  // -128 negates to 0x80, which is the correct unsigned magnitude.
  assign neg_a = multiplier[W-1];
  assign neg_b = multiplicand[W-1];
  assign mag_a = neg_a ? (~multiplier) + {{(W-1){1'b0}}, 1'b1} : multiplier;
  assign mag_b = neg_b ? (~multiplicand) + {{(W-1){1'b0}}, 1'b1} : multiplicand;
  assign negative = sign_q & (acc != '0);
`else
  assign mag_a    = multiplier;
  assign mag_b    = multiplicand;
  assign negative = 1'b0;
`endif

  assign product = acc;

  // Sequencer and shift-add datapath; multiplicand shifts left instead of a barrel shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef SIGNED_OPS_EN
      sign_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mplier_q <= mag_a;
            mcand_q  <= {{W{1'b0}}, mag_b};
            acc      <= '0;
            cnt      <= '0;
`ifdef SIGNED_OPS_EN
            sign_q   <= neg_a ^ neg_b;
`endif
            busy     <= 1'b1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == CNT_W'(W)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            if (mplier_q[0])
              acc <= acc + mcand_q;
            mplier_q <= mplier_q >> 1;
            mcand_q  <= mcand_q << 1;
            cnt      <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (!start) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  bin2bcd_dd u_bcd (
    .bin (acc),
    .bcd (bcd)
  );

endmodule

// File: tb/tb_signed_mult_bcd.sv
// Self-checking bench for signed_mult_bcd with a scoreboard of expected results.
module tb_signed_mult_bcd;

  localparam int W = 8;

  typedef struct {
    logic [15:0] prod;
    logic [19:0] bcd;
    logic        neg;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  multiplier;
  logic [7:0]  multiplicand;
  logic [15:0] product;
  logic [19:0] bcd;
  logic        negative;
  logic        done;
  logic        busy;

  int   n_vec;
  int   n_err;
  exp_t sb[$];

  signed_mult_bcd #(.W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .product      (product),
    .bcd          (bcd),
    .negative     (negative),
    .done         (done),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t        e;
    logic [7:0]  ma;
    logic [7:0]  mb;
    logic        s;
    int          p;
    int          pw;
`ifdef SIGNED_OPS_EN
    ma = a[7] ? 8'(0 - a) : a;
    mb = b[7] ? 8'(0 - b) : b;
    s  = a[7] ^ b[7];
`else
    ma = a;
    mb = b;
    s  = 1'b0;
`endif
    p      = int'(ma) * int'(mb);
    e.prod = 16'(p);
    e.neg  = s && (p != 0);
    pw     = 1;
    e.bcd  = '0;
    for (int d = 0; d < 5; d++) begin
      e.bcd[4*d +: 4] = 4'((p / pw) % 10);
      pw = pw * 10;
    end
    return e;
  endfunction

  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    multiplier   = a;
    multiplicand = b;
    start        = 1'b1;
    sb.push_back(model(a, b));
  endtask

  // lat = edges after the sampling edge until done is seen, -1 on timeout
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic drop_start();
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_result(input string name);
    int   lat;
    exp_t e;
    wait_done(lat);
    n_vec++;
    if (lat < 0) begin
      n_err++;
      $display("FAIL %s timeout: done never rose", name);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (lat !== W + 1) begin
      n_err++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, W + 1);
    end
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    n_vec++;
    if (product !== e.prod) begin
      n_err++;
      $display("FAIL %s product: got %0d want %0d", name, product, e.prod);
    end
    n_vec++;
    if (bcd !== e.bcd) begin
      n_err++;
      $display("FAIL %s bcd: got %05h want %05h", name, bcd, e.bcd);
    end
    n_vec++;
    if (negative !== e.neg) begin
      n_err++;
      $display("FAIL %s negative: got %0b want %0b", name, negative, e.neg);
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s busy_at_done: got %0b want 0", name, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    multiplier = '0;
    multiplicand = '0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({product, bcd, negative, done, busy} !== '0) begin
      n_err++;
      $display("FAIL reset_values: got p=%0d bcd=%05h n=%0b d=%0b b=%0b want all 0",
               product, bcd, negative, done, busy);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    exp_t e;
    launch(8'hFB, 8'd10);
    e = sb[0];
    @(posedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL basic busy: got %0b want 1", busy);
    end
    multiplier   = 8'h33;
    multiplicand = 8'h81;
    // wait_done counts from the next edge, so adjust by shifting one edge back
    begin
      int lat;
      lat = -1;
      for (int k = 1; k < 40; k++) begin
        @(posedge clk);
        #1;
        if (done === 1'b1) begin
          lat = k;
          break;
        end
      end
      n_vec++;
      if (lat !== W + 1) begin
        n_err++;
        $display("FAIL basic latency: got %0d want %0d", lat, W + 1);
      end
    end
    void'(sb.pop_front());
    n_vec++;
    if (product !== e.prod || bcd !== e.bcd || negative !== e.neg) begin
      n_err++;
      $display("FAIL basic result: got %0d/%05h/%0b want %0d/%05h/%0b",
               product, bcd, negative, e.prod, e.bcd, e.neg);
    end
    repeat (5) @(negedge clk);
    n_vec++;
    if (done !== 1'b1 || product !== e.prod || bcd !== e.bcd || negative !== e.neg) begin
      n_err++;
      $display("FAIL basic hold: got d=%0b %0d/%05h/%0b want d=1 %0d/%05h/%0b",
               done, product, bcd, negative, e.prod, e.bcd, e.neg);
    end
    drop_start();
  endtask

  task automatic test_extremes();
    launch(8'h80, 8'h80);
    check_result("min_x_min");
    drop_start();
    launch(8'h00, 8'hF9);
    check_result("zero_x_neg");
    drop_start();
    launch(8'hFF, 8'hFF);
    check_result("ff_x_ff");
    drop_start();
  endtask

  task automatic test_drop_start();
    launch(8'd127, 8'hFF);
    check_result("drop_127");
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL drop_done_clear: got d=%0b b=%0b want 0/0", done, busy);
    end
    launch(8'd3, 8'd3);
    check_result("restart_3x3");
    drop_start();
  endtask

  task automatic test_short_pulse();
    @(negedge clk);
    #1 start = 1'b1;
    #2 start = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL short_pulse: got b=%0b d=%0b want 0/0", busy, done);
    end
  endtask

  task automatic test_reset_abort();
    launch(8'd12, 8'd12);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    void'(sb.pop_front());
    #1;
    n_vec++;
    if ({product, bcd, negative, done, busy} !== '0) begin
      n_err++;
      $display("FAIL abort_values: got p=%0d bcd=%05h n=%0b d=%0b b=%0b want all 0",
               product, bcd, negative, done, busy);
    end
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    launch(8'd12, 8'd12);
    check_result("after_abort");
    drop_start();
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      launch(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      check_result("random");
      drop_start();
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_extremes();
    test_drop_start();
    test_short_pulse();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
